// File: rtl/falafel_lsu.sv
// falafel_lsu: load/store unit between the falafel allocator FSM and the memory holding
// free-list block headers and the global lock word. It services one request at a time,
// turning each operation into a sequence of 64-bit word accesses on a single memory port.
//
// Optional feature: define FALAFEL_LSU_LOCK_BACKOFF_EN to insert BACKOFF_CYCLES idle cycles
// (LOCK_BACKOFF) between a failed lock read and its retry.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_i/req_ready_o   request (val, op, header_data); accepted when val && ready
//   rsp_o/rsp_ready_i   response (val, header_data); consumed when val && ready
//   mem_req_o ...       registered memory command, held until mem_gnt_i
//   mem_gnt_i           access accepted; writes complete at grant
//   mem_rvalid_i/rdata  read data, one or more cycles after grant

package falafel_lsu_pkg;

    typedef enum logic [2:0] {
        LsuLock,
        LsuUnlock,
        LsuLoad,
        LsuSetInsertAddr,
        LsuInsert,
        LsuDelete
    } req_lsu_op_e;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] size;
        logic [63:0] next_addr;
    } header_data_t;

    typedef struct packed {
        logic         val;
        req_lsu_op_e  op;
        header_data_t header_data;
    } header_data_req_t;

    typedef struct packed {
        logic         val;
        header_data_t header_data;
    } header_data_rsp_t;

    localparam logic [63:0] BLOCK_NEXT_ADDR_OFFSET = 64'd8;

endpackage

module falafel_lsu
    import falafel_lsu_pkg::*;
#(
    parameter logic [63:0] LOCK_ADDR      = 64'h0,
    parameter int unsigned BACKOFF_CYCLES = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  header_data_req_t req_i,
    output logic             req_ready_o,
    output header_data_rsp_t rsp_o,
    input  logic             rsp_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [63:0]      mem_addr_o,
    output logic [63:0]      mem_wdata_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [63:0]      mem_rdata_i
);

    if (BACKOFF_CYCLES < 1) begin : g_backoff_check
        $error("BACKOFF_CYCLES must be at least 1");
    end

    typedef enum logic [3:0] {
        StIdle, StLockRd, StLockWait, StLockBackoff, StLockWr, StUnlockWr,
        StLdSize, StLdSizeWait, StLdNext, StLdNextWait,
        StInsSize, StInsNext, StInsLink, StDelWr, StRsp
    } state_e;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } mem_cmd_t;

    function automatic mem_cmd_t rd_cmd(input logic [63:0] addr);
        rd_cmd = '{req: 1'b1, we: 1'b0, addr: addr, wdata: 64'h0};
    endfunction

    function automatic mem_cmd_t wr_cmd(input logic [63:0] addr, input logic [63:0] data);
        wr_cmd = '{req: 1'b1, we: 1'b1, addr: addr, wdata: data};
    endfunction

    state_e       state_q, state_d;
    header_data_t hdr_q, hdr_d;
    logic [63:0]  insert_addr_q, insert_addr_d;
    mem_cmd_t     mem_q, mem_d;
    logic         gnt;
`ifdef FALAFEL_LSU_LOCK_BACKOFF_EN
    logic [31:0]  cnt_q, cnt_d;
`endif

    // A grant only counts against a command that is actually being presented.
    assign gnt = mem_q.req && mem_gnt_i;

    always_comb begin
        state_d       = state_q;
        hdr_d         = hdr_q;
        insert_addr_d = insert_addr_q;
        mem_d         = mem_q;
`ifdef FALAFEL_LSU_LOCK_BACKOFF_EN
        cnt_d         = cnt_q;
`endif
        // Drop the request after grant; a follow-on issue below re-asserts it.
        if (gnt) begin
            mem_d.req = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (req_i.val) begin
                    hdr_d = req_i.header_data;
                    case (req_i.op)
                        LsuLock: begin
                            state_d = StLockRd;
                            mem_d   = rd_cmd(LOCK_ADDR);
                        end
                        LsuUnlock: begin
                            state_d = StUnlockWr;
                            mem_d   = wr_cmd(LOCK_ADDR, 64'h0);
                        end
                        LsuLoad: begin
                            state_d = StLdSize;
                            mem_d   = rd_cmd(req_i.header_data.addr);
                        end
                        LsuSetInsertAddr: begin
                            insert_addr_d = req_i.header_data.addr;
                            state_d       = StRsp;
                        end
                        LsuInsert: begin
                            state_d = StInsSize;
                            mem_d   = wr_cmd(req_i.header_data.addr, req_i.header_data.size);
                        end
                        LsuDelete: begin
                            state_d = StDelWr;
                            mem_d   = wr_cmd(req_i.header_data.addr + BLOCK_NEXT_ADDR_OFFSET,
                                             req_i.header_data.next_addr);
                        end
                        default: state_d = StRsp;
                    endcase
                end
            end
            StLockRd: if (gnt) state_d = StLockWait;
            StLockWait: begin
                if (mem_rvalid_i) begin
                    if (mem_rdata_i == 64'h0) begin
                        state_d = StLockWr;
                        mem_d   = wr_cmd(LOCK_ADDR, 64'd1);
                    end else begin
`ifdef FALAFEL_LSU_LOCK_BACKOFF_EN
                        state_d = StLockBackoff;
                        cnt_d   = BACKOFF_CYCLES - 1;
`else
                        state_d = StLockRd;
                        mem_d   = rd_cmd(LOCK_ADDR);
`endif
                    end
                end
            end
            StLockBackoff: begin
`ifdef FALAFEL_LSU_LOCK_BACKOFF_EN
                if (cnt_q == '0) begin
                    state_d = StLockRd;
                    mem_d   = rd_cmd(LOCK_ADDR);
                end else begin
                    cnt_d = cnt_q - 1;
                end
`else
                state_d = StLockRd;
                mem_d   = rd_cmd(LOCK_ADDR);
`endif
            end
            StLockWr, StUnlockWr, StDelWr, StInsLink: if (gnt) state_d = StRsp;
            StLdSize: if (gnt) state_d = StLdSizeWait;
            StLdSizeWait: begin
                if (mem_rvalid_i) begin
                    hdr_d.size = mem_rdata_i;
                    state_d    = StLdNext;
                    mem_d      = rd_cmd(hdr_q.addr + BLOCK_NEXT_ADDR_OFFSET);
                end
            end
            StLdNext: if (gnt) state_d = StLdNextWait;
            StLdNextWait: begin
                if (mem_rvalid_i) begin
                    hdr_d.next_addr = mem_rdata_i;
                    state_d         = StRsp;
                end
            end
            StInsSize: begin
                if (gnt) begin
                    state_d = StInsNext;
                    mem_d   = wr_cmd(hdr_q.addr + BLOCK_NEXT_ADDR_OFFSET, hdr_q.next_addr);
                end
            end
            StInsNext: begin
                if (gnt) begin
                    // Link the predecessor block to the newly inserted one.
                    state_d = StInsLink;
                    mem_d   = wr_cmd(insert_addr_q + BLOCK_NEXT_ADDR_OFFSET, hdr_q.addr);
                end
            end
            StRsp: if (rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            hdr_q         <= '0;
            insert_addr_q <= '0;
            mem_q         <= '0;
`ifdef FALAFEL_LSU_LOCK_BACKOFF_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            hdr_q         <= hdr_d;
            insert_addr_q <= insert_addr_d;
            mem_q         <= mem_d;
`ifdef FALAFEL_LSU_LOCK_BACKOFF_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign rsp_o       = '{val: (state_q == StRsp), header_data: hdr_q};
    assign mem_req_o   = mem_q.req;
    assign mem_we_o    = mem_q.we;
    assign mem_addr_o  = mem_q.addr;
    assign mem_wdata_o = mem_q.wdata;

endmodule
